fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: FIFO word width (DW).
REQ-003 SHALL have parameter ADDR_WIDTH, default 3: FIFO address width (AW); depth 2**AW.
REQ-004 SHALL have parameter MAX_BEATS, default 16: maximum beats per burst before forced release.
REQ-005 SHALL have parameter MIN_FREE, default 2: free FIFO slots required to start a burst (used only under REQ-027).
REQ-006 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-007 SHALL have port rstn_i, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports req_valid_i / req_last_i, input, NREQ each: per-requester beat valid and last-beat-of-burst.
REQ-009 SHALL have port req_data_i, input, NREQ*DW: requester i data at bits [i*DW +: DW].
REQ-010 SHALL have port req_ready_o, output, NREQ: per-requester beat accept.
REQ-011 SHALL have ports fifo_we_o (1), fifo_wdata_o (DW), output: FIFO write-side enable and data.
REQ-012 SHALL have ports fifo_full_i (1), fifo_wfill_count_i (AW), input: FIFO write-side full flag and fill count.
REQ-013 SHALL have port grant_o, output, NREQ: registered one-hot current owner, zero when idle.
REQ-014 SHALL have ports busy_o (1), output: high in BURST; overrun_o (NREQ), output: sticky forced-release flags; overrun_clr_i (NREQ), input: per-bit clear.

Function
REQ-015 SHALL implement two states, IDLE and BURST, with a registered one-hot grant and a registered last-owner index.
REQ-016 In IDLE, when any req_valid_i is high, SHALL select the first valid requester searching round-robin from last-owner+1 (wrapping modulo NREQ), load grant, and enter BURST next cycle; arbitration latency is one cycle, and no beat is accepted in IDLE.
REQ-017 req_ready_o[i] SHALL equal grant[i] AND state==BURST AND NOT fifo_full_i (combinational on fifo_full_i).
REQ-018 A beat SHALL be accepted when req_valid_i[i] and req_ready_o[i] are both high; fifo_we_o SHALL equal the OR of accepted beats; fifo_wdata_o SHALL be the granted requester's data (all zeros when no grant).
REQ-019 The grant SHALL be held while the owner deasserts valid or the FIFO is full; no other requester is served mid-burst.
REQ-020 A 5-bit-or-wider beat counter SHALL count accepted beats in BURST and clear on entry to BURST.
REQ-021 An accepted beat with req_last_i high SHALL return to IDLE, clear grant, and set last-owner to the owner.
REQ-022 An accepted beat without last that makes the beat count equal MAX_BEATS SHALL return to IDLE, clear grant, update last-owner, and set overrun_o[owner].
REQ-023 A last beat that is also the MAX_BEATS-th beat SHALL be a normal end with no overrun.
REQ-024 overrun_o[i] SHALL clear on overrun_clr_i[i]; a same-cycle set SHALL win over clear.

Reset
REQ-025 On rstn_i low, SHALL asynchronously force state IDLE, grant_o 0, busy_o 0, overrun_o 0, beat count 0, and last-owner NREQ-1, so requester 0 has first priority; fifo_we_o and req_ready_o are 0 as a consequence.
REQ-026 A reset asserted mid-burst SHALL abandon the burst with no further FIFO writes; partial data already in the FIFO is not retracted.

Configuration
REQ-027 With macro FIFO_WR_ARB_WATERMARK_EN defined, IDLE SHALL start a burst only when free slots, computed as 0 when fifo_full_i is high and otherwise 2**AW minus fifo_wfill_count_i, are at least MIN_FREE; without it, a burst starts regardless of FIFO level.

Verification
REQ-028 Reset release, req_valid_i=4'b1111, each burst 1 beat with last -> grant_o order 0001,0010,0100,1000,0001; one idle cycle between bursts.
REQ-029 Owner 2 sends a 3-beat burst, drops valid for 2 cycles after beat 1 while requester 0 is valid -> grant_o stays 0100; FIFO receives exactly 3 words in order.
REQ-030 fifo_full_i high for 4 cycles mid-burst -> req_ready_o and fifo_we_o low for those cycles; no data lost or duplicated.
REQ-031 Requester 1 streams with no last, MAX_BEATS=16 -> release after the 16th accepted beat, overrun_o=4'b0010; overrun_clr_i pulse clears it; 16th beat with last gives no overrun.
REQ-032 Macro defined, MIN_FREE=2, fill count 7 (depth 8), requester valid -> no grant until fill count falls to 6; macro undefined -> grant after one cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-oriented write arbiter in front of a FIFO
//            write port. One requester owns the FIFO for a whole burst, which
//            ends on an accepted last beat or after MAX_BEATS beats (forced
//            release, flagged in the sticky overrun_o bits).
// Options  : FIFO_WR_ARB_WATERMARK_EN - when defined, a burst only starts if
//            the FIFO has at least MIN_FREE free slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int MAX_BEATS  = 16,
  parameter int MIN_FREE   = 2
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ-1:0]              req_last_i,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]              req_ready_o,
  output logic                         fifo_we_o,
  output logic [DATA_WIDTH-1:0]        fifo_wdata_o,
  input  logic                         fifo_full_i,
  input  logic [ADDR_WIDTH-1:0]        fifo_wfill_count_i,
  output logic [NREQ-1:0]              grant_o,
  output logic                         busy_o,
  output logic [NREQ-1:0]              overrun_o,
  input  logic [NREQ-1:0]              overrun_clr_i
);

  localparam int IW = $clog2(NREQ);
  // Beat counter is at least 5 bits wide and always able to hold MAX_BEATS.
  localparam int CW = ($clog2(MAX_BEATS + 1) > 5) ? $clog2(MAX_BEATS + 1) : 5;

  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    BURST = 1'b1;

  localparam logic [IW-1:0] LAST_OWNER_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] MAX_CNT        = CW'(MAX_BEATS);

  logic [0:0]            state;
  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         last_owner;
  logic [CW-1:0]         beat_cnt;
  logic [NREQ-1:0]       overrun;

  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         cand;
  logic                  start_ok;
  logic                  in_burst;
  logic [NREQ-1:0]       accepted;
  logic                  beat_acc;
  logic                  acc_last;
  logic [CW-1:0]         cnt_inc;
  logic                  hit_max;
  logic [NREQ-1:0]       overrun_set;
  logic [DATA_WIDTH-1:0] wdata;

  // Round-robin search: first valid requester starting after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_owner) + k) % NREQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef FIFO_WR_ARB_WATERMARK_EN
  // Free slots are forced to zero on full, since the fill count wraps at depth.
  logic [ADDR_WIDTH:0] free_slots;
  always_comb begin
    free_slots = '0;
    if (!fifo_full_i) begin
      free_slots = ((ADDR_WIDTH+1)'(1) << ADDR_WIDTH) - {1'b0, fifo_wfill_count_i};
    end
    start_ok = (free_slots >= (ADDR_WIDTH+1)'(MIN_FREE));
  end
`else
  // Without the watermark a burst starts regardless of FIFO level.
  localparam int unused_min_free = MIN_FREE;
  logic unused_fill;
  assign unused_fill = ^fifo_wfill_count_i;
  assign start_ok    = 1'b1;
`endif

  assign in_burst    = (state == BURST);
  assign req_ready_o = grant & {NREQ{in_burst && !fifo_full_i}};
  assign accepted    = req_valid_i & req_ready_o;
  assign beat_acc    = |accepted;
  assign acc_last    = |(accepted & req_last_i);
  assign cnt_inc     = beat_cnt + CW'(1);
  assign hit_max     = (cnt_inc == MAX_CNT);
  assign overrun_set = (beat_acc && !acc_last && hit_max) ? grant : '0;

  // Write data follows the grant; zero when nobody owns the FIFO.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wdata = wdata | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_we_o    = beat_acc;
  assign fifo_wdata_o = wdata;
  assign grant_o      = grant;
  assign busy_o       = in_burst;
  assign overrun_o    = overrun;

  // Arbitration FSM: grant in IDLE, count beats and release in BURST.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= LAST_OWNER_RST;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && start_ok) begin
            state    <= BURST;
            grant    <= NREQ'(1) << pick_idx;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (beat_acc) begin
            beat_cnt <= cnt_inc;
            if (acc_last || hit_max) begin
              state      <= IDLE;
              grant      <= '0;
              last_owner <= owner;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Sticky forced-release flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overrun <= '0;
    end else begin
      overrun <= (overrun & ~overrun_clr_i) | overrun_set;
    end
  end

endmodule

`default_nettype wire
